// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the core-to-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MAX_D_RUN_DEF = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of one single-port memory with
// one-cycle read latency; data has priority, bounded by a D-run limit.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_D_RUN = MAX_D_RUN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              igrant,
  output logic              ivalid,
  output logic [DATA_W-1:0] irdata,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic              dgrant,
  output logic              dvalid,
  output logic [DATA_W-1:0] drdata,
  output logic              mreq,
  output logic              mwe,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mwdata,
  input  logic [DATA_W-1:0] mrdata
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

  owner_e     own_q, own_d;
  logic [3:0] run_q, run_d;
  logic       dwr_q, dwr_d;
  logic       d_win;

  always_comb begin
    // D wins unless fetch is waiting and D has already used its run budget.
    d_win  = dreq & ~(ireq & (run_q == RUN_MAX));
    dgrant = ~reset & d_win;
    igrant = ~reset & ireq & ~d_win;

    mreq   = igrant | dgrant;
    mwe    = dgrant & dwe;
    maddr  = dgrant ? daddr : (igrant ? iaddr : '0);
    mwdata = (dgrant & dwe) ? dwdata : '0;

    // Reset gates the response so a pending access is dropped, not returned.
    ivalid = ~reset & (own_q == OWN_I);
    dvalid = ~reset & (own_q == OWN_D);
    irdata = ivalid ? mrdata : '0;
    drdata = (dvalid & ~dwr_q) ? mrdata : '0;

    own_d = dgrant ? OWN_D : (igrant ? OWN_I : OWN_NONE);
    dwr_d = dgrant & dwe;

    run_d = run_q;
    if (~ireq | igrant) begin
      run_d = '0;
    end else if (dgrant && (run_q != RUN_MAX)) begin
      run_d = run_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q <= OWN_NONE;
      run_q <= '0;
      dwr_q <= 1'b0;
    end else begin
      own_q <= own_d;
      run_q <= run_d;
      dwr_q <= dwr_d;
    end
  end

endmodule
